pump_rotation_ctrl: RTL



---
 rtl/pump_rotation_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/pump_rotation_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pump_rotation_ctrl
// Description : N-pump tank controller. Thermometer-coded level sensors are
//               synchronised and turned into a pump demand count. The demand
//               is served by healthy pumps taken in order from a rotating lead
//               pointer. Each pump has a minimum run time, and a faulted pump
//               is dropped and bypassed.
// Revision    : 1.0 - initial release
// ============================================================================
module pump_rotation_ctrl #(
  parameter int N_PUMPS = 2,
  parameter int MIN_ON  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_PUMPS-1:0]         lvl,
  input  logic [N_PUMPS-1:0]         pump_fault,
  output logic [N_PUMPS-1:0]         pump,
  output logic [$clog2(N_PUMPS)-1:0] lead,
  output logic                       short_alarm,
  output logic                       sensor_err
);

  // Width of the lead index, width of a demand/pump count (0..N_PUMPS),
  // and width of a run counter (0..MIN_ON-1).
  localparam int c_lw = $clog2(N_PUMPS);
  localparam int c_dw = $clog2(N_PUMPS + 1);
  localparam int c_cw = $clog2(MIN_ON + 1);

  // Registered state
  logic [N_PUMPS-1:0] r_lvl_meta;
  logic [N_PUMPS-1:0] r_lvl_s;
  logic [c_dw-1:0]    r_d_prev;
  logic [c_lw-1:0]    r_lead;
  logic [N_PUMPS-1:0] r_pump;
  logic               r_short;
  logic               r_err;

  // Combinational intermediates
  logic [N_PUMPS:0]   w_lvl_ext;
  logic               w_valid;
  logic [c_dw-1:0]    w_ones;
  logic [c_dw-1:0]    w_hcount;
  logic [c_dw-1:0]    w_d;
  logic [c_dw-1:0]    w_take;
  logic               w_start;
  logic [N_PUMPS-1:0] w_healthy;
  logic [c_lw-1:0]    w_lead_nxt;
  logic [N_PUMPS-1:0] w_want;
  logic [N_PUMPS-1:0] w_pump_nxt;

  assign w_healthy = ~pump_fault;

  // A valid thermometer code is 2^k-1. Adding one then clears every set bit.
  assign w_lvl_ext = {1'b0, r_lvl_s};
  assign w_valid   = ((w_lvl_ext + (N_PUMPS + 1)'(1)) & w_lvl_ext) == '0;

  // Count the active level sensors and the healthy pumps.
  always_comb begin
    w_ones   = '0;
    w_hcount = '0;
    for (int i = 0; i < N_PUMPS; i++) begin
      w_ones   = w_ones + c_dw'(r_lvl_s[i]);
      w_hcount = w_hcount + c_dw'(w_healthy[i]);
    end
  end

  // An invalid sensor code keeps the previous demand. The previous demand is
  // always derived from a valid code, so it is the last valid value.
  assign w_d     = w_valid ? (c_dw'(N_PUMPS) - w_ones) : r_d_prev;
  assign w_start = (r_d_prev == '0) && (w_d != '0);
  assign w_take  = (w_d < w_hcount) ? w_d : w_hcount;

  // Pick the lead used this cycle. On a start event it moves to the next
  // healthy pump after the current one. If every pump is faulted, it holds.
  always_comb begin
    logic [c_lw-1:0] idx;
    logic            found;
    w_lead_nxt = r_lead;
    idx        = '0;
    found      = 1'b0;
    if (w_start) begin
      for (int k = 1; k <= N_PUMPS; k++) begin
        idx = c_lw'((int'(r_lead) + k) % N_PUMPS);
        if (!found && w_healthy[idx]) begin
          w_lead_nxt = idx;
          found      = 1'b1;
        end
      end
    end
  end

  // Request the first w_take healthy pumps, scanning upward from the lead.
  always_comb begin
    logic [c_lw-1:0] idx;
    logic [c_dw-1:0] taken;
    w_want = '0;
    idx    = '0;
    taken  = '0;
    for (int k = 0; k < N_PUMPS; k++) begin
      idx = c_lw'((int'(w_lead_nxt) + k) % N_PUMPS);
      if (w_healthy[idx] && (taken < w_take)) begin
        w_want[idx] = 1'b1;
        taken       = taken + c_dw'(1);
      end
    end
  end

  // Per-pump minimum-run-time counter and next enable. A fault overrides
  // both the request and the hold.
  for (genvar g = 0; g < N_PUMPS; g++) begin : g_pump
    logic [c_cw-1:0] r_cnt;

    assign w_pump_nxt[g] = w_healthy[g] &
                           (w_want[g] | (r_pump[g] & (r_cnt != '0)));

    // Load MIN_ON-1 on turn-on, count down while on, clear when off.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_cnt <= '0;
      end else if (!w_pump_nxt[g]) begin
        r_cnt <= '0;
      end else if (!r_pump[g]) begin
        r_cnt <= c_cw'(MIN_ON - 1);
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - c_cw'(1);
      end
    end
  end

  // Two-flop sensor synchroniser. The reset value decodes to full demand.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lvl_meta <= '0;
      r_lvl_s    <= '0;
    end else begin
      r_lvl_meta <= lvl;
      r_lvl_s    <= r_lvl_meta;
    end
  end

  // Demand history, lead pointer, pump enables and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d_prev <= '0;
      r_lead   <= c_lw'(N_PUMPS - 1);
      r_pump   <= '0;
      r_short  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_d_prev <= w_d;
      r_lead   <= w_lead_nxt;
      r_pump   <= w_pump_nxt;
      r_short  <= (w_d > w_hcount);
      r_err    <= ~w_valid;
    end
  end

  assign pump        = r_pump;
  assign lead        = r_lead;
  assign short_alarm = r_short;
  assign sensor_err  = r_err;

endmodule
`default_nettype wire
